spi_wb_arbiter: RTL and testbench
=================================

Name: spi_wb_arbiter

Overview:
- Two-master, one-slave arbiter for the wishbone register port of the SPI master core (`spi_top`).
- Master 0 is the XIP flash-read sequencer. Master 1 is the APB-to-register pass-through for direct software access to the SPI master.
- A `lock` input per master keeps ownership across a multi-access sequence (TX, DIVIDER, SS, CTRL, poll, RX, SS release). This stops software from corrupting an in-flight XIP read, and stops XIP from corrupting a software transfer.

Parameters:
- ADDR_W, 5, wishbone address width.
- DATA_W, 32, wishbone data width.
- LOCK_TIMEOUT, 1024, idle-locked cycles before the arbiter forcibly releases ownership; must be >= 2.

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- m0_cyc, m0_stb, m0_we  in  1 each  master 0 wishbone control
- m0_adr  in  ADDR_W  master 0 address
- m0_dat_i  in  DATA_W  master 0 write data
- m0_sel  in  4  master 0 byte enables
- m0_lock  in  1  master 0 holds ownership while high
- m0_ack  out  1  ack to master 0
- m0_err  out  1  error to master 0
- m0_dat_o  out  DATA_W  read data to master 0
- m1_* : same set as m0_*, for master 1
- s_cyc, s_stb, s_we  out  1 each  to `spi_top`
- s_adr  out  ADDR_W  to `spi_top`
- s_dat_o  out  DATA_W  write data to `spi_top`
- s_sel  out  4  to `spi_top`
- s_ack, s_err  in  1 each  from `spi_top`
- s_dat_i  in  DATA_W  read data from `spi_top`
- grant  out  2  one-hot owner: bit0 = m0, bit1 = m1, 00 = none
- timeout_pulse  out  1  one-cycle pulse on forced release

Behaviour:
- Reset:
  - grant = 00, state IDLE, timeout counter 0, timeout_pulse 0.
  - All s_* outputs 0; all mN_ack/mN_err 0.
  - Reset asserted mid-transfer drops s_cyc/s_stb in the same cycle, because the outputs are decoded from registered state.
- States: IDLE, OWN0, OWN1. grant is the registered one-hot encoding of the state.
- IDLE:
  - If m0_cyc, go to OWN0.
  - Else if m1_cyc, go to OWN1.
  - Fixed priority, m0 highest.
  - Arbitration latency is one cycle: a request seen at edge k is granted from edge k+1.
- OWNn, slave side:
  - s_* = mN_* combinationally.
  - Non-owner inputs are ignored.
  - In IDLE, s_cyc = s_stb = s_we = 0, and s_adr/s_dat_o/s_sel = 0.
- OWNn, master side:
  - mN_ack = s_ack & grant[n]; mN_err = s_err & grant[n].
  - Both mN_dat_o are driven with s_dat_i; only the acked master samples it.
  - A non-owner sees ack = err = 0, so its cycle stalls.
- Release: in OWNn, when mN_cyc = 0 and mN_lock = 0 at a clock edge:
  - the other master's cyc is high: switch directly to its OWN state (no IDLE gap);
  - otherwise: go to IDLE.
- No release is possible while the owner's cyc is high, so a transfer is never split.
- Timeout:
  - The counter increments in OWNn while mN_cyc = 0 and mN_lock = 1; it clears otherwise and on every state change.
  - When it reaches LOCK_TIMEOUT-1, the arbiter performs a forced release (same next-state rule as a normal release) and timeout_pulse = 1 for exactly one cycle.
  - A cyc assertion in the same cycle as the terminal count cancels the forced release.
- Simultaneous requests in IDLE: m0 wins (see optional feature).
- The owner may re-assert cyc any number of times while locked; each transfer passes straight through with zero added latency.

Optional Feature:
- Macro: SPI_WB_ARB_RR_EN.
- Defined:
  - A 1-bit last_owner register (reset 0) records the most recent owner.
  - On simultaneous cyc requests, whether from IDLE or at a release, the master that is not last_owner wins.
  - This guarantees m1 is granted within one m0 ownership.
- Undefined: fixed priority, m0 always wins ties; no last_owner register.

Test Plan:
- Single m0 access:
  - Stimulus: m0_cyc = m0_stb = 1, we = 1, adr = 0x04, data = 0x03001234; spi_top acks 1 cycle later.
  - Response: grant = 01 one cycle after the request; s_adr = 0x04, s_dat_o = 0x03001234; m0_ack pulses; m1_ack stays 0; back to IDLE the cycle after cyc drops.
- Lock sequence:
  - Stimulus: m0_lock = 1 across 7 transfers with 3-cycle gaps; m1_cyc held high throughout.
  - Response: grant stays 01 across all gaps; m1 is never acked; grant goes 01 -> 10 directly at the edge after m0_lock falls.
- Tie:
  - Stimulus: m0_cyc and m1_cyc rise in the same cycle from IDLE.
  - Response: without the macro, grant = 01. With SPI_WB_ARB_RR_EN and last_owner = 0, grant = 10.
- Timeout:
  - Stimulus: LOCK_TIMEOUT = 8; m1 owns with lock = 1 and cyc = 0 for 8 cycles.
  - Response: timeout_pulse high exactly one cycle; grant 10 -> 00, or 10 -> 01 if m0_cyc is high.
- Reset mid-transfer:
  - Stimulus: assert reset while m1 owns with s_cyc = 1.
  - Response: s_cyc, grant and m1_ack are 0 immediately (asynchronous); after reset release, IDLE and re-arbitration works.
- Read data routing:
  - Stimulus: m1 reads adr 0x10; spi_top returns s_dat_i = 0x00000140 with ack.
  - Response: m1_dat_o = 0x00000140 sampled with m1_ack; m0_ack = 0.

Source files
------------

// File: rtl/spi_wb_arbiter.sv
// spi_wb_arbiter: two-master / one-slave wishbone arbiter in front of the
// spi_top register port. Master 0 is the XIP read sequencer, master 1 the
// APB pass-through. A per-master lock holds ownership across a sequence
// of accesses. An idle-locked timeout forcibly releases a stuck owner.
// Optional build macro: SPI_WB_ARB_RR_EN selects round-robin tie-break
// through a last_owner register. The default build uses fixed m0 priority.
module spi_wb_arbiter #(
    parameter int unsigned ADDR_W       = 5,
    parameter int unsigned DATA_W       = 32,
    parameter int unsigned LOCK_TIMEOUT = 1024
) (
    input  logic              clock,
    input  logic              reset,

    input  logic              m0_cyc,
    input  logic              m0_stb,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_adr,
    input  logic [DATA_W-1:0] m0_dat_i,
    input  logic [3:0]        m0_sel,
    input  logic              m0_lock,
    output logic              m0_ack,
    output logic              m0_err,
    output logic [DATA_W-1:0] m0_dat_o,

    input  logic              m1_cyc,
    input  logic              m1_stb,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_adr,
    input  logic [DATA_W-1:0] m1_dat_i,
    input  logic [3:0]        m1_sel,
    input  logic              m1_lock,
    output logic              m1_ack,
    output logic              m1_err,
    output logic [DATA_W-1:0] m1_dat_o,

    output logic              s_cyc,
    output logic              s_stb,
    output logic              s_we,
    output logic [ADDR_W-1:0] s_adr,
    output logic [DATA_W-1:0] s_dat_o,
    output logic [3:0]        s_sel,
    input  logic              s_ack,
    input  logic              s_err,
    input  logic [DATA_W-1:0] s_dat_i,

    output logic [1:0]        grant,
    output logic              timeout_pulse
);

    localparam int unsigned CNT_W = $clog2(LOCK_TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_TIMEOUT - 1);

    // One-hot state encoding doubles as the grant vector
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        OWN0 = 2'b01,
        OWN1 = 2'b10
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             hold_c;
    logic             forced_c;
    logic             release_c;

`ifdef SPI_WB_ARB_RR_EN
    logic             last_owner_q;

    // Remember who was granted most recently for the tie-break
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            last_owner_q <= 1'b0;
        end else if (state_d == OWN0) begin
            last_owner_q <= 1'b0;
        end else if (state_d == OWN1) begin
            last_owner_q <= 1'b1;
        end
    end
`endif

    // State register, idle-locked counter and timeout pulse
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            timeout_pulse <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            timeout_pulse <= forced_c;
        end
    end

    // Next-state: arbitration from IDLE, normal or forced release from OWNn
    always_comb begin
        state_d   = state_q;
        hold_c    = 1'b0;
        forced_c  = 1'b0;
        release_c = 1'b0;
        case (state_q)
            IDLE: begin
                if (m0_cyc && m1_cyc) begin
`ifdef SPI_WB_ARB_RR_EN
                    state_d = last_owner_q ? OWN0 : OWN1;
`else
                    state_d = OWN0;
`endif
                end else if (m0_cyc) begin
                    state_d = OWN0;
                end else if (m1_cyc) begin
                    state_d = OWN1;
                end
            end
            OWN0: begin
                hold_c    = !m0_cyc && m0_lock;
                forced_c  = hold_c && (cnt_q == CNT_LAST);
                release_c = (!m0_cyc && !m0_lock) || forced_c;
                if (release_c) begin
                    state_d = m1_cyc ? OWN1 : IDLE;
                end
            end
            OWN1: begin
                hold_c    = !m1_cyc && m1_lock;
                forced_c  = hold_c && (cnt_q == CNT_LAST);
                release_c = (!m1_cyc && !m1_lock) || forced_c;
                if (release_c) begin
                    state_d = m0_cyc ? OWN0 : IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        // Counter runs only while the owner sits locked and idle; any release clears it
        cnt_d = (hold_c && !release_c) ? cnt_q + CNT_W'(1) : '0;
    end

    // Outputs: route owner to slave and slave responses to owner
    always_comb begin
        s_cyc    = 1'b0;
        s_stb    = 1'b0;
        s_we     = 1'b0;
        s_adr    = '0;
        s_dat_o  = '0;
        s_sel    = '0;
        m0_ack   = 1'b0;
        m0_err   = 1'b0;
        m1_ack   = 1'b0;
        m1_err   = 1'b0;
        m0_dat_o = s_dat_i;
        m1_dat_o = s_dat_i;
        case (state_q)
            OWN0: begin
                s_cyc   = m0_cyc;
                s_stb   = m0_stb;
                s_we    = m0_we;
                s_adr   = m0_adr;
                s_dat_o = m0_dat_i;
                s_sel   = m0_sel;
                m0_ack  = s_ack;
                m0_err  = s_err;
            end
            OWN1: begin
                s_cyc   = m1_cyc;
                s_stb   = m1_stb;
                s_we    = m1_we;
                s_adr   = m1_adr;
                s_dat_o = m1_dat_i;
                s_sel   = m1_sel;
                m1_ack  = s_ack;
                m1_err  = s_err;
            end
            default: begin
            end
        endcase
    end

    assign grant = state_q;

endmodule

// File: tb/tb_spi_wb_arbiter.sv
// Bench for spi_wb_arbiter: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against an owner-level model.
module tb_spi_wb_arbiter;

    localparam int unsigned ADDR_W = 5;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned LT     = 8;
`ifdef SPI_WB_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic              clock = 1'b0;
    logic              reset;
    logic              m0_cyc, m0_stb, m0_we, m0_lock;
    logic [ADDR_W-1:0] m0_adr;
    logic [DATA_W-1:0] m0_dat_i;
    logic [3:0]        m0_sel;
    logic              m0_ack, m0_err;
    logic [DATA_W-1:0] m0_dat_o;
    logic              m1_cyc, m1_stb, m1_we, m1_lock;
    logic [ADDR_W-1:0] m1_adr;
    logic [DATA_W-1:0] m1_dat_i;
    logic [3:0]        m1_sel;
    logic              m1_ack, m1_err;
    logic [DATA_W-1:0] m1_dat_o;
    logic              s_cyc, s_stb, s_we;
    logic [ADDR_W-1:0] s_adr;
    logic [DATA_W-1:0] s_dat_o;
    logic [3:0]        s_sel;
    logic              s_ack, s_err;
    logic [DATA_W-1:0] s_dat_i;
    logic [1:0]        grant;
    logic              timeout_pulse;

    spi_wb_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LOCK_TIMEOUT(LT)
    ) dut (
        .clock(clock), .reset(reset),
        .m0_cyc(m0_cyc), .m0_stb(m0_stb), .m0_we(m0_we), .m0_adr(m0_adr),
        .m0_dat_i(m0_dat_i), .m0_sel(m0_sel), .m0_lock(m0_lock),
        .m0_ack(m0_ack), .m0_err(m0_err), .m0_dat_o(m0_dat_o),
        .m1_cyc(m1_cyc), .m1_stb(m1_stb), .m1_we(m1_we), .m1_adr(m1_adr),
        .m1_dat_i(m1_dat_i), .m1_sel(m1_sel), .m1_lock(m1_lock),
        .m1_ack(m1_ack), .m1_err(m1_err), .m1_dat_o(m1_dat_o),
        .s_cyc(s_cyc), .s_stb(s_stb), .s_we(s_we), .s_adr(s_adr),
        .s_dat_o(s_dat_o), .s_sel(s_sel), .s_ack(s_ack), .s_err(s_err),
        .s_dat_i(s_dat_i), .grant(grant), .timeout_pulse(timeout_pulse)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_errors = 0;
    bit chk_en   = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at t=%0t", nm, act, exp, $time);
        end
    endtask

    // Model: who owns the slave (-1 none), how many consecutive
    // locked-idle cycles the owner has spent, and the pulse due this cycle.
    int          owner    = -1;
    int unsigned held     = 0;
    bit          exp_pulse = 1'b0;
    bit          last_own = 1'b0;
    int          m_nxt;
    bit          m_forced, m_oc, m_ol, m_xc;

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            owner     = -1;
            held      = 0;
            exp_pulse = 1'b0;
            last_own  = 1'b0;
        end else begin
            m_nxt    = owner;
            m_forced = 1'b0;
            if (owner < 0) begin
                if (m0_cyc && m1_cyc) m_nxt = (RR && !last_own) ? 1 : 0;
                else if (m0_cyc)      m_nxt = 0;
                else if (m1_cyc)      m_nxt = 1;
            end else begin
                m_oc = (owner == 0) ? m0_cyc  : m1_cyc;
                m_ol = (owner == 0) ? m0_lock : m1_lock;
                m_xc = (owner == 0) ? m1_cyc  : m0_cyc;
                if (!m_oc && m_ol) begin
                    held     = held + 1;
                    m_forced = (held == LT);
                end else begin
                    held = 0;
                end
                if ((!m_oc && !m_ol) || m_forced) begin
                    m_nxt = m_xc ? (1 - owner) : -1;
                    held  = 0;
                end
            end
            if (m_nxt == 0) last_own = 1'b0;
            if (m_nxt == 1) last_own = 1'b1;
            owner     = m_nxt;
            exp_pulse = m_forced;
        end
    end

    // Per-cycle compare of every DUT output against the model
    always @(negedge clock) begin
        if (chk_en) begin
            chk("grant", 32'(grant), (owner == 0) ? 32'd1 : (owner == 1) ? 32'd2 : 32'd0);
            chk("timeout_pulse", 32'(timeout_pulse), 32'(exp_pulse));
            chk("s_cyc", 32'(s_cyc), (owner == 0) ? 32'(m0_cyc) : (owner == 1) ? 32'(m1_cyc) : 32'd0);
            chk("s_stb", 32'(s_stb), (owner == 0) ? 32'(m0_stb) : (owner == 1) ? 32'(m1_stb) : 32'd0);
            chk("s_we", 32'(s_we), (owner == 0) ? 32'(m0_we) : (owner == 1) ? 32'(m1_we) : 32'd0);
            chk("s_adr", 32'(s_adr), (owner == 0) ? 32'(m0_adr) : (owner == 1) ? 32'(m1_adr) : 32'd0);
            chk("s_dat_o", s_dat_o, (owner == 0) ? m0_dat_i : (owner == 1) ? m1_dat_i : 32'd0);
            chk("s_sel", 32'(s_sel), (owner == 0) ? 32'(m0_sel) : (owner == 1) ? 32'(m1_sel) : 32'd0);
            chk("m0_ack", 32'(m0_ack), (owner == 0) ? 32'(s_ack) : 32'd0);
            chk("m0_err", 32'(m0_err), (owner == 0) ? 32'(s_err) : 32'd0);
            chk("m1_ack", 32'(m1_ack), (owner == 1) ? 32'(s_ack) : 32'd0);
            chk("m1_err", 32'(m1_err), (owner == 1) ? 32'(s_err) : 32'd0);
            chk("m0_dat_o", m0_dat_o, s_dat_i);
            chk("m1_dat_o", m1_dat_o, s_dat_i);
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_inputs();
        m0_cyc = 0; m0_stb = 0; m0_we = 0; m0_adr = '0; m0_dat_i = '0; m0_sel = '0; m0_lock = 0;
        m1_cyc = 0; m1_stb = 0; m1_we = 0; m1_adr = '0; m1_dat_i = '0; m1_sel = '0; m1_lock = 0;
        s_ack = 0; s_err = 0; s_dat_i = '0;
    endtask

    task automatic rand_inputs();
        if ($urandom_range(0, 3) == 0) m0_cyc = ~m0_cyc;
        if ($urandom_range(0, 3) == 0) m1_cyc = ~m1_cyc;
        if ($urandom_range(0, 9) == 0) m0_lock = ~m0_lock;
        if ($urandom_range(0, 9) == 0) m1_lock = ~m1_lock;
        m0_stb   = m0_cyc & ($urandom_range(0, 3) != 0);
        m1_stb   = m1_cyc & ($urandom_range(0, 3) != 0);
        m0_we    = 1'($urandom);
        m1_we    = 1'($urandom);
        m0_adr   = ADDR_W'($urandom);
        m1_adr   = ADDR_W'($urandom);
        m0_dat_i = $urandom;
        m1_dat_i = $urandom;
        m0_sel   = 4'($urandom);
        m1_sel   = 4'($urandom);
        s_ack    = 1'($urandom);
        s_err    = ($urandom_range(0, 7) == 0);
        s_dat_i  = $urandom;
    endtask

    initial begin
        clear_inputs();
        reset = 1'b1;
        s_ack = 1'b1;
        s_err = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        chk("rst_grant", 32'(grant), 32'd0);
        chk("rst_s_cyc", 32'(s_cyc), 32'd0);
        chk("rst_pulse", 32'(timeout_pulse), 32'd0);
        chk("rst_m0_ack", 32'(m0_ack), 32'd0);
        chk("rst_m1_err", 32'(m1_err), 32'd0);
        s_ack = 0; s_err = 0;
        reset = 1'b0;
        chk_en = 1'b1;

        // Tie from IDLE with last_owner at reset value
        m0_cyc = 1; m0_stb = 1; m1_cyc = 1; m1_stb = 1;
        tick();
        chk("tie_grant", 32'(grant), RR ? 32'd2 : 32'd1);
        clear_inputs();
        tick();
        chk("tie_release", 32'(grant), 32'd0);

        // Single m0 write
        m0_cyc = 1; m0_stb = 1; m0_we = 1; m0_adr = 5'h04; m0_dat_i = 32'h0300_1234; m0_sel = 4'hf;
        #1;
        chk("m0_pre_grant", 32'(grant), 32'd0);
        chk("m0_pre_s_cyc", 32'(s_cyc), 32'd0);
        tick();
        chk("m0_grant", 32'(grant), 32'd1);
        chk("m0_s_adr", 32'(s_adr), 32'h04);
        chk("m0_s_dat", s_dat_o, 32'h0300_1234);
        chk("m0_s_we", 32'(s_we), 32'd1);
        s_ack = 1;
        #1;
        chk("m0_ack", 32'(m0_ack), 32'd1);
        chk("m0_m1_ack", 32'(m1_ack), 32'd0);
        tick();
        clear_inputs();
        #1;
        chk("m0_hold_grant", 32'(grant), 32'd1);
        tick();
        chk("m0_idle", 32'(grant), 32'd0);

        // Locked m0 sequence with m1 waiting
        m0_lock = 1; m0_cyc = 1; m0_stb = 1; m0_adr = 5'h08;
        tick();
        chk("lock_grant", 32'(grant), 32'd1);
        m1_cyc = 1; m1_stb = 1; m1_adr = 5'h0c;
        for (int t = 0; t < 7; t++) begin
            m0_cyc = 1; m0_stb = 1; s_ack = 1; s_dat_i = 32'(t) * 32'h11;
            #1;
            chk("lock_m0_ack", 32'(m0_ack), 32'd1);
            chk("lock_m1_ack", 32'(m1_ack), 32'd0);
            tick();
            m0_cyc = 0; m0_stb = 0; s_ack = 0;
            for (int g = 0; g < 3; g++) begin
                tick();
                chk("lock_gap_grant", 32'(grant), 32'd1);
            end
        end
        m0_lock = 0;
        tick();
        chk("lock_handover", 32'(grant), 32'd2);
        s_ack = 1;
        #1;
        chk("handover_m1_ack", 32'(m1_ack), 32'd1);
        chk("handover_s_adr", 32'(s_adr), 32'h0c);
        tick();
        clear_inputs();
        tick();
        chk("handover_idle", 32'(grant), 32'd0);

        // Timeout to IDLE, to m0, and cancelled at terminal count
        for (int v = 0; v < 3; v++) begin
            m1_cyc = 1; m1_stb = 1;
            tick();
            chk("to_grant", 32'(grant), 32'd2);
            m1_cyc = 0; m1_stb = 0; m1_lock = 1;
            if (v == 1) m0_cyc = 1;
            for (int i = 0; i < int'(LT) - 1; i++) begin
                tick();
                chk("to_wait_pulse", 32'(timeout_pulse), 32'd0);
                chk("to_wait_grant", 32'(grant), 32'd2);
            end
            if (v == 2) m1_cyc = 1;
            tick();
            chk("to_pulse", 32'(timeout_pulse), (v == 2) ? 32'd0 : 32'd1);
            chk("to_after", 32'(grant), (v == 0) ? 32'd0 : (v == 1) ? 32'd1 : 32'd2);
            tick();
            chk("to_pulse_gone", 32'(timeout_pulse), 32'd0);
            clear_inputs();
            repeat (2) tick();
            chk("to_idle", 32'(grant), 32'd0);
        end

        // Async reset while m1 owns a live cycle
        m1_cyc = 1; m1_stb = 1; m1_we = 1; m1_adr = 5'h08;
        tick();
        s_ack = 1;
        #1;
        chk("rmid_s_cyc", 32'(s_cyc), 32'd1);
        chk("rmid_m1_ack", 32'(m1_ack), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        chk("rmid_s_cyc_rst", 32'(s_cyc), 32'd0);
        chk("rmid_grant_rst", 32'(grant), 32'd0);
        chk("rmid_m1_ack_rst", 32'(m1_ack), 32'd0);
        clear_inputs();
        tick();
        reset = 1'b0;
        tick();
        chk("rmid_idle", 32'(grant), 32'd0);
        m0_cyc = 1; m0_stb = 1;
        tick();
        chk("rmid_rearb", 32'(grant), 32'd1);
        clear_inputs();
        tick();

        // m1 register read routed back with ack
        m1_cyc = 1; m1_stb = 1; m1_we = 0; m1_adr = 5'h10; m1_sel = 4'hf;
        tick();
        s_dat_i = 32'h0000_0140; s_ack = 1;
        #1;
        chk("rd_m1_ack", 32'(m1_ack), 32'd1);
        chk("rd_m1_dat", m1_dat_o, 32'h0000_0140);
        chk("rd_m0_ack", 32'(m0_ack), 32'd0);
        chk("rd_s_adr", 32'(s_adr), 32'h10);
        tick();
        clear_inputs();
        tick();

        // Randomized traffic; the compare process checks each cycle
        for (int c = 0; c < 4000; c++) begin
            rand_inputs();
            tick();
        end

        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
